// File: rtl/multdiv_issue_ctrl_if.sv
// Bus between the pipeline-side issue sequencer and its neighbours.
// Carries the execute-stage issue, the multiplier/divider unit handshake
// and the register-file writeback.
//   slave  : the sequencer (multdiv_issue_ctrl)
//   master : the pipeline / unit environment driving issue and unit results
interface multdiv_issue_ctrl_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      issue_mult;
  logic                      issue_div;
  logic [DATA_WIDTH-1:0]     operand_a;
  logic [DATA_WIDTH-1:0]     operand_b;
  logic [REG_ADDR_WIDTH-1:0] dest_reg;
  logic                      md_ctrl_mult;
  logic                      md_ctrl_div;
  logic [DATA_WIDTH-1:0]     md_operand_a;
  logic [DATA_WIDTH-1:0]     md_operand_b;
  logic [DATA_WIDTH-1:0]     md_result;
  logic                      md_exception;
  logic                      md_result_rdy;
  logic                      stall;
  logic                      wb_valid;
  logic [REG_ADDR_WIDTH-1:0] wb_reg;
  logic [DATA_WIDTH-1:0]     wb_data;

  modport slave (
    input  issue_mult, issue_div, operand_a, operand_b, dest_reg,
    input  md_result, md_exception, md_result_rdy,
    output md_ctrl_mult, md_ctrl_div, md_operand_a, md_operand_b,
    output stall, wb_valid, wb_reg, wb_data
  );

  modport master (
    output issue_mult, issue_div, operand_a, operand_b, dest_reg,
    output md_result, md_exception, md_result_rdy,
    input  md_ctrl_mult, md_ctrl_div, md_operand_a, md_operand_b,
    input  stall, wb_valid, wb_reg, wb_data
  );
endinterface

// File: rtl/multdiv_issue_ctrl.sv
// Pipeline-side sequencer for the shared multiplier/divider unit.
// Captures a MULT/DIV from execute, issues a one-cycle start pulse, holds the
// operands and stalls the pipeline until the unit is ready (or a timeout),
// then performs one register-file writeback: the result, or an exception code
// into RSTATUS_REG.
// Ports:
//   clock  : single clock, all state on posedge
//   reset  : synchronous, active-high
//   bus    : multdiv_issue_ctrl_if.slave (issue, unit handshake, writeback)
module multdiv_issue_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int RSTATUS_REG    = 30,
  parameter int MULT_EXC_CODE  = 1,
  parameter int DIV_EXC_CODE   = 2,
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic                  clock,
  input  logic                  reset,
  multdiv_issue_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, START, BUSY, WB} state_t;

  state_t                    state;
  state_t                    state_next;
  logic                      op_mult;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0]     a_q;
  logic [DATA_WIDTH-1:0]     b_q;
  logic [DATA_WIDTH-1:0]     result_q;
  logic                      exc_q;
  logic [5:0]                counter;
  logic                      capture;
  logic                      accept;
  logic                      timeout;

  // counter holds the number of BUSY cycles already completed, so it is zero
  // only in the first BUSY cycle, where a lingering ready is ignored.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    accept     = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.issue_mult || bus.issue_div) begin
          capture    = 1'b1;
          state_next = START;
        end
      end
      START: state_next = BUSY;
      BUSY: begin
        if (counter != '0 && bus.md_result_rdy) begin
          accept     = 1'b1;
          state_next = WB;
        end else if (counter + 6'd1 == 6'(TIMEOUT_CYCLES)) begin
          timeout    = 1'b1;
          state_next = WB;
        end
      end
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= '0;
      op_mult  <= 1'b0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (capture) begin
        // MULT has priority when both issue lines are high.
        op_mult <= bus.issue_mult;
        rd_q    <= bus.dest_reg;
        a_q     <= bus.operand_a;
        b_q     <= bus.operand_b;
      end
      if (state == START) begin
        counter <= '0;
      end else if (state == BUSY) begin
        counter <= counter + 6'd1;
      end
      if (accept) begin
        result_q <= bus.md_result;
        exc_q    <= bus.md_exception;
      end else if (timeout) begin
        result_q <= '0;
        exc_q    <= 1'b1;
      end
    end
  end

  // All outputs decode registered state only.
  assign bus.md_ctrl_mult = (state == START) &&  op_mult;
  assign bus.md_ctrl_div  = (state == START) && !op_mult;
  assign bus.md_operand_a = a_q;
  assign bus.md_operand_b = b_q;
  assign bus.stall        = (state != IDLE);
  // A normal write to r0 is dropped; exception writes always go to RSTATUS_REG.
  assign bus.wb_valid     = (state == WB) && (exc_q || rd_q != '0);
  assign bus.wb_reg       = (state != WB) ? '0 :
                            exc_q ? REG_ADDR_WIDTH'(RSTATUS_REG) : rd_q;
  assign bus.wb_data      = (state != WB) ? '0 :
                            !exc_q ? result_q :
                            op_mult ? DATA_WIDTH'(MULT_EXC_CODE) : DATA_WIDTH'(DIV_EXC_CODE);

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
module tb_multdiv_issue_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  multdiv_issue_ctrl_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  multdiv_issue_ctrl #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .RSTATUS_REG(30),
    .MULT_EXC_CODE(1), .DIV_EXC_CODE(2), .TIMEOUT_CYCLES(40)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wb_t;

  wb_t sb[$];
  wb_t exp_wb;
  int  checks = 0;
  int  errors = 0;
  int  n_mult = 0;
  int  n_div  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of the multiplier/divider unit.
  function automatic void unit_model(input logic m, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] res, output logic exc);
    logic signed [63:0] p;
    if (m) begin
      p   = $signed(a) * $signed(b);
      res = p[31:0];
      exc = (p != {{32{p[31]}}, p[31:0]});
    end else if (b == '0) begin
      res = '0;
      exc = 1'b1;
    end else begin
      res = $signed(a) / $signed(b);
      exc = 1'b0;
    end
  endfunction

  always @(negedge clock) begin
    if (bus.md_ctrl_mult) n_mult++;
    if (bus.md_ctrl_div)  n_div++;
    if (bus.wb_valid) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 1, 0);
      end else begin
        exp_wb = sb.pop_front();
        check("wb_reg",  bus.wb_reg,  exp_wb.r);
        check("wb_data", bus.wb_data, exp_wb.d);
      end
    end
  end

  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int rdy_k, input logic stale, input logic never);
    logic        mult_op;
    logic [31:0] res;
    logic        exc;
    logic        exp_valid;
    int          busy_len;
    int          pm;
    int          pd;
    mult_op = m;
    unit_model(mult_op, a, b, res, exc);
    exp_valid = never || exc || (rd != 5'd0);
    if (exp_valid)
      sb.push_back('{r: (never || exc) ? 5'd30 : rd,
                     d: (never || exc) ? (mult_op ? 32'd1 : 32'd2) : res});
    busy_len = never ? 40 : rdy_k;
    pm = n_mult;
    pd = n_div;

    @(negedge clock);
    bus.issue_mult    = m;
    bus.issue_div     = d;
    bus.operand_a     = a;
    bus.operand_b     = b;
    bus.dest_reg      = rd;
    bus.md_result     = res;
    bus.md_exception  = exc;
    bus.md_result_rdy = stale;

    @(negedge clock);
    bus.issue_mult = 1'b0;
    bus.issue_div  = 1'b0;
    bus.operand_a  = $urandom;
    bus.operand_b  = $urandom;
    bus.dest_reg   = 5'($urandom_range(0, 31));
    check("start_mult", bus.md_ctrl_mult, mult_op);
    check("start_div",  bus.md_ctrl_div,  !mult_op);
    check("stall_start", bus.stall, 1);

    for (int k = 1; k <= busy_len; k++) begin
      @(negedge clock);
      check("stall_busy", bus.stall, 1);
      check("wb_early", bus.wb_valid, 0);
      bus.md_result_rdy = !never && ((k == rdy_k) || (stale && k == 1));
    end

    @(negedge clock);
    bus.md_result_rdy = 1'b0;
    check("stall_wb", bus.stall, 1);
    check("wb_valid", bus.wb_valid, exp_valid);
    check("hold_a", bus.md_operand_a, a);
    check("hold_b", bus.md_operand_b, b);

    @(negedge clock);
    check("stall_release", bus.stall, 0);
    check("wb_after", bus.wb_valid, 0);
    check("mult_pulses", n_mult - pm, mult_op ? 1 : 0);
    check("div_pulses",  n_div - pd,  mult_op ? 0 : 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.issue_mult    = 1'b0;
    bus.issue_div     = 1'b0;
    bus.operand_a     = '0;
    bus.operand_b     = '0;
    bus.dest_reg      = '0;
    bus.md_result     = '0;
    bus.md_exception  = 1'b0;
    bus.md_result_rdy = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_stall", bus.stall, 0);
    check("rst_wb", bus.wb_valid, 0);
    check("rst_ctrl", {bus.md_ctrl_mult, bus.md_ctrl_div}, 0);
    check("rst_opa", bus.md_operand_a, 0);
    check("rst_opb", bus.md_operand_b, 0);
    reset = 1'b0;

    run_op(1'b1, 1'b0, 32'd6, 32'd7, 5'd5, 3, 1'b0, 1'b0);
    run_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 5'd9, 2, 1'b0, 1'b0);
    run_op(1'b0, 1'b1, 32'd5, 32'd0, 5'd12, 4, 1'b0, 1'b0);
    run_op(1'b1, 1'b0, 32'h4000_0000, 32'd4, 5'd7, 2, 1'b0, 1'b0);
    run_op(1'b1, 1'b1, 32'd3, 32'hFFFF_FFFB, 5'd11, 2, 1'b1, 1'b0);
    run_op(1'b0, 1'b1, 32'd100, 32'd3, 5'd6, 0, 1'b0, 1'b1);

    // Reset in the third BUSY cycle: back to IDLE, no writeback.
    @(negedge clock);
    bus.issue_mult = 1'b1;
    bus.operand_a  = 32'd3;
    bus.operand_b  = 32'd3;
    bus.dest_reg   = 5'd4;
    @(negedge clock);
    bus.issue_mult = 1'b0;
    repeat (3) @(negedge clock);
    check("busy_before_rst", bus.stall, 1);
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_stall", bus.stall, 0);
    check("rst_mid_ctrl", {bus.md_ctrl_mult, bus.md_ctrl_div}, 0);
    check("rst_mid_opa", bus.md_operand_a, 0);
    check("rst_mid_wb", bus.wb_valid, 0);
    reset = 1'b0;
    bus.md_result_rdy = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_mid_idle", bus.stall, 0);
    bus.md_result_rdy = 1'b0;

    run_op(1'b1, 1'b0, 32'd9, 32'd9, 5'd0, 2, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      logic m;
      m = 1'($urandom_range(0, 1));
      run_op(m, !m, 32'($urandom_range(0, 1000)), 32'($urandom_range(0, 20)),
             5'($urandom_range(0, 31)), $urandom_range(2, 6), 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) @(negedge clock);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
